// File: rtl/multicycle_control_pkg.sv
// Shared types and constants for the multi-cycle control unit.
//   state_t     : FSM state encoding
//   OP_*        : opcode values (low three opcode bits)
//   ALU_*       : ALU function codes driven on alu_op
//   ctrl_word_t : decoded control word, registered in DECODE
package ctrl_pkg;

  localparam int unsigned ALU_OP_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4
  } state_t;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_SLT = 3'd2;
  localparam logic [2:0] OP_SW  = 3'd3;
  localparam logic [2:0] OP_LW  = 3'd4;
  localparam logic [2:0] OP_AND = 3'd5;
  localparam logic [2:0] OP_OR  = 3'd6;
  localparam logic [2:0] OP_NOP = 3'd7;

  localparam logic [ALU_OP_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OP_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OP_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALU_OP_W-1:0] ALU_SLT = 4'b0111;

  typedef struct packed {
    logic [ALU_OP_W-1:0] alu_op;
    logic                alu_src;
    logic                reg_dst;
    logic                mem_to_reg;
    logic                mem_read;
    logic                mem_write;
    logic                is_mem;
    logic                is_nop;
    logic                illegal;
  } ctrl_word_t;

endpackage

// File: rtl/multicycle_control_if.sv
// Bundle of the control unit's fetch handshake, data-memory handshake and
// datapath strobes.
//   master : the control unit (drives ready, mem_req and all strobes)
//   slave  : fetch stage / memory / datapath side
interface multicycle_control_if #(
  parameter int unsigned OPCODE_W = 3
);
  logic                instr_valid;
  logic                instr_ready;
  logic [OPCODE_W-1:0] opcode;
  logic                mem_req;
  logic                mem_ack;
  logic                alu_en;
  logic [3:0]          alu_op;
  logic                alu_src;
  logic                reg_dst;
  logic                reg_write;
  logic                mem_to_reg;
  logic                mem_write;
  logic                mem_read;
  logic                busy;
  logic                illegal_op;
  logic                err_timeout;

  modport master (
    input  instr_valid, opcode, mem_ack,
    output instr_ready, mem_req, alu_en, alu_op, alu_src, reg_dst, reg_write,
           mem_to_reg, mem_write, mem_read, busy, illegal_op, err_timeout
  );

  modport slave (
    output instr_valid, opcode, mem_ack,
    input  instr_ready, mem_req, alu_en, alu_op, alu_src, reg_dst, reg_write,
           mem_to_reg, mem_write, mem_read, busy, illegal_op, err_timeout
  );
endinterface

// File: rtl/multicycle_control_decode.sv
// ctrl_decode: purely combinational opcode -> control word mapping.
//   opcode : OPCODE_W-bit instruction opcode (OPCODE_W >= 2)
//   cw     : decoded ctrl_word_t; only cw.illegal set for codes >= 8
module ctrl_decode
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W = 3
) (
  input  logic [OPCODE_W-1:0] opcode,
  output ctrl_word_t          cw
);

  // Zero-extend so the low three bits and the "upper" bits exist for any width.
  localparam int unsigned EXT_W = OPCODE_W + 3;

  logic [EXT_W-1:0] ext;

  always_comb begin
    ext = EXT_W'(opcode);
    cw  = '0;
    case (ext[2:0])
      OP_ADD: begin cw.alu_op = ALU_ADD; cw.reg_dst = 1'b1; end
      OP_SUB: begin cw.alu_op = ALU_SUB; cw.reg_dst = 1'b1; end
      OP_SLT: begin cw.alu_op = ALU_SLT; cw.reg_dst = 1'b1; end
      OP_AND: begin cw.alu_op = ALU_AND; cw.reg_dst = 1'b1; end
      OP_OR:  begin cw.alu_op = ALU_OR;  cw.reg_dst = 1'b1; end
      OP_SW: begin
        cw.alu_op    = ALU_ADD;
        cw.alu_src   = 1'b1;
        cw.mem_write = 1'b1;
        cw.is_mem    = 1'b1;
      end
      OP_LW: begin
        cw.alu_op     = ALU_ADD;
        cw.alu_src    = 1'b1;
        cw.mem_read   = 1'b1;
        cw.mem_to_reg = 1'b1;
        cw.is_mem     = 1'b1;
      end
      OP_NOP:  cw.is_nop  = 1'b1;
      default: cw.illegal = 1'b1;
    endcase
    // Any bit above bit 2 set means the code is outside the defined map.
    if (|(ext >> 3)) begin
      cw         = '0;
      cw.illegal = 1'b1;
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: sequences one opcode per handshake through
// DECODE / EXEC / MEM / WB, drives datapath strobes and runs the data-memory
// req/ack handshake with a MEM_TIMEOUT-cycle abort.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : multicycle_control_if.master (fetch handshake, memory handshake,
//           datapath strobes, busy / illegal_op / err_timeout)
// Every output is a function of state_q, cw_q, opcode_q or err_q only.
module multicycle_control
  import ctrl_pkg::*;
#(
  parameter int unsigned OPCODE_W    = 3,
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  multicycle_control_if.master  bus
);

  localparam int unsigned CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(MEM_TIMEOUT - 1);

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] opcode_q;
  ctrl_word_t          dec;
  ctrl_word_t          cw_q;
  logic [CNT_W-1:0]    wait_q;
  logic                err_q;
  logic                timeout_c;
  logic                unused_cw;

  assign unused_cw = ^{cw_q.is_nop, cw_q.illegal};

  ctrl_decode #(.OPCODE_W(OPCODE_W)) u_decode (
    .opcode (opcode_q),
    .cw     (dec)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Opcode / control-word capture, MEM wait counter, timeout pulse flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opcode_q <= '0;
      cw_q     <= '0;
      wait_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      err_q <= timeout_c;
      if (state_q == IDLE && bus.instr_valid) opcode_q <= bus.opcode;
      if (state_q == DECODE) cw_q <= dec;
      if (state_q == EXEC) begin
        wait_q <= '0;
      end else if (state_q == MEM && !bus.mem_ack) begin
        wait_q <= wait_q + CNT_W'(1);
      end
    end
  end

  // Next state and state-decoded outputs.
  always_comb begin
    state_d         = state_q;
    timeout_c       = 1'b0;
    bus.instr_ready = 1'b0;
    bus.mem_req     = 1'b0;
    bus.alu_en      = 1'b0;
    bus.alu_op      = ALU_AND;
    bus.alu_src     = 1'b0;
    bus.reg_dst     = 1'b0;
    bus.reg_write   = 1'b0;
    bus.mem_to_reg  = 1'b0;
    bus.mem_write   = 1'b0;
    bus.mem_read    = 1'b0;
    bus.busy        = (state_q != IDLE);
    bus.illegal_op  = 1'b0;
    bus.err_timeout = err_q;

    case (state_q)
      IDLE: begin
        bus.instr_ready = 1'b1;
        if (bus.instr_valid) state_d = DECODE;
      end
      DECODE: begin
        bus.illegal_op = dec.illegal;
        if (dec.illegal || dec.is_nop) state_d = IDLE;
        else                           state_d = EXEC;
      end
      EXEC: begin
        bus.alu_en  = 1'b1;
        bus.alu_op  = cw_q.alu_op;
        bus.alu_src = cw_q.alu_src;
        bus.reg_dst = cw_q.reg_dst;
        state_d     = cw_q.is_mem ? MEM : WB;
      end
      MEM: begin
        bus.mem_req   = 1'b1;
        bus.alu_op    = cw_q.alu_op;
        bus.mem_write = cw_q.mem_write;
        bus.mem_read  = cw_q.mem_read;
        // An ack on the last allowed cycle takes priority over the abort.
        if (bus.mem_ack) begin
          state_d = cw_q.mem_read ? WB : IDLE;
        end else if (wait_q == LAST_WAIT) begin
          state_d   = IDLE;
          timeout_c = 1'b1;
        end
      end
      WB: begin
        bus.reg_write  = 1'b1;
        bus.alu_op     = cw_q.alu_op;
        bus.reg_dst    = cw_q.reg_dst;
        bus.mem_to_reg = cw_q.mem_to_reg;
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (OPCODE_W=4, MEM_TIMEOUT=4).
// Cycle n is the clock period after edge n, edge 0 being the handshake edge;
// outputs are sampled on the falling edge, inputs change right after sampling.
module tb_multicycle_control;
  import ctrl_pkg::*;

  localparam int unsigned OPCODE_W    = 4;
  localparam int unsigned MEM_TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  multicycle_control_if #(.OPCODE_W(OPCODE_W)) bus ();

  multicycle_control #(.OPCODE_W(OPCODE_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Observed outputs, packed:
  // {ready, req, alu_en, alu_op[3:0], src, dst, wr, m2r, mw, mr, busy, ill, tmo}
  function automatic logic [15:0] outs();
    return {bus.instr_ready, bus.mem_req, bus.alu_en, bus.alu_op, bus.alu_src,
            bus.reg_dst, bus.reg_write, bus.mem_to_reg, bus.mem_write,
            bus.mem_read, bus.busy, bus.illegal_op, bus.err_timeout};
  endfunction

  function automatic logic [15:0] ex(input logic rdy, input logic req,
      input logic en, input logic [3:0] op, input logic src, input logic dst,
      input logic wr, input logic m2r, input logic mw, input logic mr,
      input logic bsy, input logic ill, input logic tmo);
    return {rdy, req, en, op, src, dst, wr, m2r, mw, mr, bsy, ill, tmo};
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs,
                     input logic [15:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input string tag, input logic [15:0] exp);
    @(negedge clk);
    chk(tag, outs(), exp);
  endtask

  logic [15:0] e_idle, e_dec;

  initial begin
    e_idle = ex(1,0,0,4'b0000,0,0,0,0,0,0,0,0,0);
    e_dec  = ex(0,0,0,4'b0000,0,0,0,0,0,0,1,0,0);

    rst_n           = 1'b0;
    bus.instr_valid = 1'b0;
    bus.opcode      = '0;
    bus.mem_ack     = 1'b0;
    #1;
    chk("reset_during", outs(), e_idle);
    @(negedge clk);
    chk("reset_during2", outs(), e_idle);
    @(negedge clk);
    rst_n = 1'b1;
    cyc("reset_after", e_idle);

    // ADD, then a NOP handshake in the first IDLE cycle after it.
    bus.instr_valid = 1'b1; bus.opcode = 4'd0;
    cyc("add_c1", e_dec);
    bus.instr_valid = 1'b0;
    cyc("add_c2_exec", ex(0,0,1,4'b0010,0,1,0,0,0,0,1,0,0));
    cyc("add_c3_wb",   ex(0,0,0,4'b0010,0,1,1,0,0,0,1,0,0));
    bus.instr_valid = 1'b1; bus.opcode = 4'd7;
    cyc("add_c4_ready", e_idle);
    cyc("nop_c1", e_dec);
    bus.instr_valid = 1'b0;
    cyc("nop_c2_ready", e_idle);

    // LW with ack in the 4th (last allowed) MEM cycle.
    bus.instr_valid = 1'b1; bus.opcode = 4'd4;
    cyc("lw_c1", e_dec);
    bus.instr_valid = 1'b0;
    cyc("lw_c2_exec", ex(0,0,1,4'b0010,1,0,0,0,0,0,1,0,0));
    cyc("lw_c3_mem",  ex(0,1,0,4'b0010,0,0,0,0,0,1,1,0,0));
    cyc("lw_c4_mem",  ex(0,1,0,4'b0010,0,0,0,0,0,1,1,0,0));
    cyc("lw_c5_mem",  ex(0,1,0,4'b0010,0,0,0,0,0,1,1,0,0));
    cyc("lw_c6_mem",  ex(0,1,0,4'b0010,0,0,0,0,0,1,1,0,0));
    bus.mem_ack = 1'b1;
    cyc("lw_c7_wb",   ex(0,0,0,4'b0010,0,0,1,1,0,0,1,0,0));
    bus.mem_ack = 1'b0;
    cyc("lw_c8_ready", e_idle);

    // SW with no ack: aborted after 4 MEM cycles, err_timeout pulses once.
    bus.instr_valid = 1'b1; bus.opcode = 4'd3;
    cyc("swto_c1", e_dec);
    bus.instr_valid = 1'b0;
    cyc("swto_c2_exec", ex(0,0,1,4'b0010,1,0,0,0,0,0,1,0,0));
    for (int i = 3; i <= 6; i++)
      cyc($sformatf("swto_c%0d_mem", i), ex(0,1,0,4'b0010,0,0,0,0,1,0,1,0,0));
    cyc("swto_c7_err", ex(1,0,0,4'b0000,0,0,0,0,0,0,0,0,1));
    cyc("swto_c8_idle", e_idle);

    // SW with ack on the final allowed cycle completes without error.
    bus.instr_valid = 1'b1; bus.opcode = 4'd3;
    cyc("swack_c1", e_dec);
    bus.instr_valid = 1'b0;
    cyc("swack_c2_exec", ex(0,0,1,4'b0010,1,0,0,0,0,0,1,0,0));
    for (int i = 3; i <= 6; i++) begin
      cyc($sformatf("swack_c%0d_mem", i), ex(0,1,0,4'b0010,0,0,0,0,1,0,1,0,0));
      if (i == 6) bus.mem_ack = 1'b1;
    end
    cyc("swack_c7_ready", e_idle);
    bus.mem_ack = 1'b0;
    cyc("swack_c8_idle", e_idle);

    // Illegal opcode 9.
    bus.instr_valid = 1'b1; bus.opcode = 4'd9;
    cyc("ill_c1", ex(0,0,0,4'b0000,0,0,0,0,0,0,1,1,0));
    bus.instr_valid = 1'b0;
    cyc("ill_c2_ready", e_idle);

    // LW interrupted by asynchronous reset while mem_req is high.
    bus.instr_valid = 1'b1; bus.opcode = 4'd4;
    cyc("rst_c1", e_dec);
    bus.instr_valid = 1'b0;
    cyc("rst_c2_exec", ex(0,0,1,4'b0010,1,0,0,0,0,0,1,0,0));
    cyc("rst_c3_mem",  ex(0,1,0,4'b0010,0,0,0,0,0,1,1,0,0));
    #2 rst_n = 1'b0;
    #1 chk("rst_async", outs(), e_idle);
    @(negedge clk);
    chk("rst_held", outs(), e_idle);
    rst_n = 1'b1;
    cyc("rst_release", e_idle);

    // SUB with instr_valid held and a stray mem_ack while busy.
    bus.instr_valid = 1'b1; bus.opcode = 4'd1;
    cyc("sub_c1", e_dec);
    bus.opcode  = 4'd4;
    bus.mem_ack = 1'b1;
    cyc("sub_c2_exec", ex(0,0,1,4'b0110,0,1,0,0,0,0,1,0,0));
    bus.mem_ack = 1'b0;
    cyc("sub_c3_wb",   ex(0,0,0,4'b0110,0,1,1,0,0,0,1,0,0));
    bus.instr_valid = 1'b0;
    cyc("sub_c4_ready", e_idle);
    cyc("sub_c5_idle",  e_idle);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
